// File: rtl/rs_dispatcher.sv
// rtl/rs_dispatcher.sv - issue stage: one-entry holding register, operand capture, CDB snooping
// Optional DISPATCH_STAT_EN adds a saturating stall_cnt output.
module rs_dispatcher #(
  parameter int ROB_ID_W = 5,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                wrong_commit,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [6:0]          dec_op,
  input  logic [XLEN-1:0]     dec_pc,
  input  logic [XLEN-1:0]     dec_imm,
  input  logic [4:0]          dec_rd,
  input  logic                dec_use_rs2,
  input  logic                dec_is_lsb,
  input  logic [ROB_ID_W-1:0] rf_Qi,
  input  logic [ROB_ID_W-1:0] rf_Qj,
  input  logic [XLEN-1:0]     rf_Vi,
  input  logic [XLEN-1:0]     rf_Vj,
  input  logic                rob_ready1,
  input  logic                rob_ready2,
  input  logic [XLEN-1:0]     rob_val1,
  input  logic [XLEN-1:0]     rob_val2,
  input  logic                rob_full,
  input  logic [ROB_ID_W-1:0] rob_next_id,
  input  logic                alu_valid,
  input  logic                lsb_valid,
  input  logic [XLEN-1:0]     alu_res,
  input  logic [XLEN-1:0]     lsb_res,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic                rs_full,
  input  logic                lsb_full,
  output logic                dispatch_valid,
  output logic                lsb_dispatch_valid,
  output logic                rob_alloc,
  output logic                rf_rename_en,
  output logic [6:0]          dispatch_op,
  output logic [XLEN-1:0]     dispatch_pc,
  output logic [XLEN-1:0]     dispatch_imm,
  output logic [ROB_ID_W-1:0] dispatch_Qi,
  output logic [ROB_ID_W-1:0] dispatch_Qj,
  output logic [XLEN-1:0]     dispatch_Vi,
  output logic [XLEN-1:0]     dispatch_Vj,
  output logic [ROB_ID_W-1:0] dispatch_rd,
  output logic [4:0]          dispatch_arch_rd
`ifdef DISPATCH_STAT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [0:0]          state;
  logic [6:0]          h_op;
  logic [XLEN-1:0]     h_pc, h_imm, h_vi, h_vj;
  logic [4:0]          h_rd;
  logic                h_lsb;
  logic [ROB_ID_W-1:0] h_qi, h_qj;

  logic                hold_valid, issue, accept;
  logic [ROB_ID_W-1:0] cap_qi, cap_qj, snp_qi, snp_qj;
  logic [XLEN-1:0]     cap_vi, cap_vj, snp_vi, snp_vj;

  assign hold_valid = (state == HELD);
  assign issue  = rdy & ~wrong_commit & hold_valid & ~rob_full & ~(h_lsb ? lsb_full : rs_full);
  assign accept = dec_valid & dec_ready;

  assign dec_ready          = rdy & ~wrong_commit & (~hold_valid | issue);
  assign dispatch_valid     = issue & ~h_lsb;
  assign lsb_dispatch_valid = issue & h_lsb;
  assign rob_alloc          = issue;
  assign rf_rename_en       = issue & (h_rd != 5'd0);

  // Buses are zero whenever nothing is held so downstream never sees stale fields.
  assign dispatch_op      = hold_valid ? h_op        : '0;
  assign dispatch_pc      = hold_valid ? h_pc        : '0;
  assign dispatch_imm     = hold_valid ? h_imm       : '0;
  assign dispatch_Qi      = hold_valid ? h_qi        : '0;
  assign dispatch_Qj      = hold_valid ? h_qj        : '0;
  assign dispatch_Vi      = hold_valid ? h_vi        : '0;
  assign dispatch_Vj      = hold_valid ? h_vj        : '0;
  assign dispatch_rd      = hold_valid ? rob_next_id : '0;
  assign dispatch_arch_rd = hold_valid ? h_rd        : '0;

  always_comb begin
    cap_qi = rf_Qi;
    cap_vi = rf_Vi;
    if (rf_Qi == '0) begin
      cap_vi = rf_Vi;
    end else if (alu_valid && alu_rob_id == rf_Qi) begin
      cap_qi = '0;
      cap_vi = alu_res;
    end else if (lsb_valid && lsb_rob_id == rf_Qi) begin
      cap_qi = '0;
      cap_vi = lsb_res;
    end else if (rob_ready1) begin
      cap_qi = '0;
      cap_vi = rob_val1;
    end

    cap_qj = rf_Qj;
    cap_vj = rf_Vj;
    if (!dec_use_rs2) begin
      cap_qj = '0;
      cap_vj = '0;
    end else if (rf_Qj == '0) begin
      cap_vj = rf_Vj;
    end else if (alu_valid && alu_rob_id == rf_Qj) begin
      cap_qj = '0;
      cap_vj = alu_res;
    end else if (lsb_valid && lsb_rob_id == rf_Qj) begin
      cap_qj = '0;
      cap_vj = lsb_res;
    end else if (rob_ready2) begin
      cap_qj = '0;
      cap_vj = rob_val2;
    end
  end

  // Held operands wake up from either CDB; ALU checked first so it wins a double match.
  always_comb begin
    snp_qi = h_qi;
    snp_vi = h_vi;
    snp_qj = h_qj;
    snp_vj = h_vj;
    if (h_qi != '0) begin
      if (alu_valid && alu_rob_id == h_qi) begin
        snp_qi = '0;
        snp_vi = alu_res;
      end else if (lsb_valid && lsb_rob_id == h_qi) begin
        snp_qi = '0;
        snp_vi = lsb_res;
      end
    end
    if (h_qj != '0) begin
      if (alu_valid && alu_rob_id == h_qj) begin
        snp_qj = '0;
        snp_vj = alu_res;
      end else if (lsb_valid && lsb_rob_id == h_qj) begin
        snp_qj = '0;
        snp_vj = lsb_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      if (wrong_commit) begin
        state <= IDLE;
      end else if (accept) begin
        state <= HELD;
        h_op  <= dec_op;
        h_pc  <= dec_pc;
        h_imm <= dec_imm;
        h_rd  <= dec_rd;
        h_lsb <= dec_is_lsb;
        h_qi  <= cap_qi;
        h_vi  <= cap_vi;
        h_qj  <= cap_qj;
        h_vj  <= cap_vj;
      end else if (issue) begin
        state <= IDLE;
      end else if (hold_valid) begin
        h_qi <= snp_qi;
        h_vi <= snp_vi;
        h_qj <= snp_qj;
        h_vj <= snp_vj;
      end
    end
  end

`ifdef DISPATCH_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (rdy && hold_valid && !issue && !wrong_commit && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
